// File: rtl/uart_frame_parser.sv
// -----------------------------------------------------------------------------
// uart_frame_parser
//
// Byte-level frame decoder behind a UART receiver. It hunts for a SOF byte,
// then reads a LEN byte, LEN payload bytes and a CSUM byte. A frame is good
// when (LEN + sum(payload) + CSUM) mod 256 == 0. Good frames are replayed from
// the internal buffer as a valid/ready byte stream with an end-of-frame
// marker. Bad length, bad checksum, overrun and timeout raise one-cycle pulses.
//
// Optional feature macro: UART_FRAME_PARSER_TIMEOUT_EN
//   defined     -> inter-byte timeout counter built, err_timeout active
//   not defined -> no counter, err_timeout tied low, parser waits forever
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   rx_data[7:0] in   received byte, qualified by rx_valid
//   rx_valid     in   single-cycle byte strobe
//   pay_data[7:0]out  payload byte
//   pay_valid    out  pay_data valid
//   pay_last     out  final payload byte of the frame
//   pay_ready    in   downstream accepts the byte
//   err_crc      out  pulse: checksum mismatch
//   err_len      out  pulse: LEN == 0 or LEN > MAX_LEN
//   err_timeout  out  pulse: inter-byte timeout
//   err_ovr      out  pulse: byte received while draining a frame
//   busy         out  parser not in IDLE
// -----------------------------------------------------------------------------
module uart_frame_parser #(
    parameter int          CLK_FREQ    = 100000000,
    parameter int          MAX_LEN     = 16,
    parameter logic [7:0]  SOF         = 8'hA5,
    parameter int          TIMEOUT_CYC = CLK_FREQ / 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] pay_data,
    output logic       pay_valid,
    output logic       pay_last,
    input  logic       pay_ready,
    output logic       err_crc,
    output logic       err_len,
    output logic       err_timeout,
    output logic       err_ovr,
    output logic       busy
);

    localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int         DEPTH     = 1 << AW;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CSUM,
        S_OUT
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      sum_q, sum_d;
    logic [AW-1:0]   wr_q, wr_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic [AW-1:0]   rd_nxt;
    logic [7:0]      pay_data_q, pay_data_d;
    logic            pay_valid_q, pay_valid_d;
    logic            pay_last_q, pay_last_d;
    logic            err_crc_q, err_crc_d;
    logic            err_len_q, err_len_d;
    logic            err_ovr_q, err_ovr_d;
    logic            busy_q;
    logic            buf_we;
    logic [7:0]      buf_q [DEPTH];

`ifdef UART_FRAME_PARSER_TIMEOUT_EN
    localparam int   CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_tmo_q, err_tmo_d;
`endif

    assign rd_nxt = rd_q + AW'(1);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        sum_d       = sum_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        pay_data_d  = pay_data_q;
        pay_valid_d = pay_valid_q;
        pay_last_d  = pay_last_q;
        err_crc_d   = 1'b0;
        err_len_d   = 1'b0;
        err_ovr_d   = 1'b0;
        buf_we      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rx_valid && rx_data == SOF) state_d = S_LEN;
            end
            S_LEN: begin
                if (rx_valid) begin
                    if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                        err_len_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        len_d   = rx_data;
                        sum_d   = rx_data;
                        wr_d    = '0;
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (rx_valid) begin
                    buf_we = 1'b1;
                    sum_d  = sum_q + rx_data;
                    wr_d   = wr_q + AW'(1);
                    if (8'(wr_q) == len_q - 8'd1) state_d = S_CSUM;
                end
            end
            S_CSUM: begin
                if (rx_valid) begin
                    if (8'(sum_q + rx_data) == 8'd0) begin
                        // Preload the first byte so pay_valid rises right after CSUM.
                        rd_d        = '0;
                        pay_data_d  = buf_q[0];
                        pay_valid_d = 1'b1;
                        pay_last_d  = (len_q == 8'd1);
                        state_d     = S_OUT;
                    end else begin
                        err_crc_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end
            S_OUT: begin
                // No input buffering while draining: incoming bytes are dropped.
                if (rx_valid) err_ovr_d = 1'b1;
                if (pay_ready) begin
                    if (pay_last_q) begin
                        pay_valid_d = 1'b0;
                        pay_last_d  = 1'b0;
                        pay_data_d  = 8'd0;
                        state_d     = S_IDLE;
                    end else begin
                        rd_d       = rd_nxt;
                        pay_data_d = buf_q[rd_nxt];
                        pay_last_d = (8'(rd_nxt) == len_q - 8'd1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef UART_FRAME_PARSER_TIMEOUT_EN
        // Counter runs only while a frame is being received; any byte restarts it.
        cnt_d     = '0;
        err_tmo_d = 1'b0;
        if ((state_q == S_LEN || state_q == S_PAYLOAD || state_q == S_CSUM) && !rx_valid) begin
            if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                err_tmo_d = 1'b1;
                state_d   = S_IDLE;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= 8'd0;
            sum_q       <= 8'd0;
            wr_q        <= '0;
            rd_q        <= '0;
            pay_data_q  <= 8'd0;
            pay_valid_q <= 1'b0;
            pay_last_q  <= 1'b0;
            err_crc_q   <= 1'b0;
            err_len_q   <= 1'b0;
            err_ovr_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            sum_q       <= sum_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            pay_data_q  <= pay_data_d;
            pay_valid_q <= pay_valid_d;
            pay_last_q  <= pay_last_d;
            err_crc_q   <= err_crc_d;
            err_len_q   <= err_len_d;
            err_ovr_q   <= err_ovr_d;
            busy_q      <= (state_d != S_IDLE);
        end
    end

    // Payload storage needs no reset: it is only read after a full good frame.
    always_ff @(posedge clk) begin
        if (buf_we) buf_q[wr_q] <= rx_data;
    end

`ifdef UART_FRAME_PARSER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            err_tmo_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            err_tmo_q <= err_tmo_d;
        end
    end
    assign err_timeout = err_tmo_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign pay_data  = pay_data_q;
    assign pay_valid = pay_valid_q;
    assign pay_last  = pay_last_q;
    assign err_crc   = err_crc_q;
    assign err_len   = err_len_q;
    assign err_ovr   = err_ovr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_parser
//
// Directed scenarios followed by randomized frames. Expected payload streams
// and error counts are built from the frame definitions themselves (checksum
// by plain modular arithmetic); a negedge monitor records handshakes, error
// pulses and hold-stability under backpressure.
// -----------------------------------------------------------------------------
module tb_uart_frame_parser;

    localparam int MAX_LEN = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] pay_data;
    logic       pay_valid;
    logic       pay_last;
    logic       pay_ready;
    logic       err_crc, err_len, err_timeout, err_ovr, busy;

    uart_frame_parser #(
        .CLK_FREQ    (100000000),
        .MAX_LEN     (MAX_LEN),
        .SOF         (8'hA5),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .pay_data    (pay_data),
        .pay_valid   (pay_valid),
        .pay_last    (pay_last),
        .pay_ready   (pay_ready),
        .err_crc     (err_crc),
        .err_len     (err_len),
        .err_timeout (err_timeout),
        .err_ovr     (err_ovr),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Monitor state
    int         cyc = 0;
    logic [8:0] got_q[$];
    int         stamp_q[$];
    int         n_crc = 0, n_len = 0, n_to = 0, n_ovr = 0, n_valid = 0;
    int         n_hold_seen = 0, n_hold_bad = 0;
    logic       hold_pend = 1'b0;
    logic [8:0] hold_val = '0;

    // Model state
    logic [8:0] exp_q[$];
    int         e_crc = 0, e_len = 0, e_to = 0, e_ovr = 0;
    logic [7:0] tx_q[$];
    logic [7:0] pl[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend <= 1'b0;
        end else begin
            if (hold_pend) begin
                n_hold_seen <= n_hold_seen + 1;
                if (!(pay_valid === 1'b1 && {pay_last, pay_data} === hold_val))
                    n_hold_bad <= n_hold_bad + 1;
            end
            hold_pend <= pay_valid && !pay_ready;
            hold_val  <= {pay_last, pay_data};
            if (pay_valid && pay_ready) begin
                got_q.push_back({pay_last, pay_data});
                stamp_q.push_back(cyc);
            end
            n_crc <= n_crc + int'(err_crc);
            n_len <= n_len + int'(err_len);
            n_to  <= n_to + int'(err_timeout);
            n_ovr <= n_ovr + int'(err_ovr);
            if (pay_valid) n_valid <= n_valid + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] csum_of(input int len, input logic [7:0] p[$]);
        int s = len;
        foreach (p[i]) s += int'(p[i]);
        return 8'((256 - (s % 256)) % 256);
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    // Sends tx_q; the final byte has no trailing gap so latency can be checked.
    task automatic send_q(input int gap);
        for (int i = 0; i < tx_q.size(); i++)
            send_byte(tx_q[i], (i == tx_q.size() - 1) ? 0 : gap);
        tx_q.delete();
    endtask

    // Builds and sends a good frame from pl, and records the expected stream.
    task automatic send_good(input int gap);
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'(pl.size()));
        foreach (pl[i]) tx_q.push_back(pl[i]);
        tx_q.push_back(csum_of(pl.size(), pl));
        foreach (pl[i]) exp_q.push_back({i == pl.size() - 1, pl[i]});
        send_q(gap);
    endtask

    task automatic drain(input bit rnd);
        bit done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(posedge clk); #1;
            pay_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        pay_ready = 1'b1;
        chk("drain_idle", busy, 0);
    endtask

    task automatic check_stream(input string tag, input bit b2b);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk({tag, "_byte"}, got_q[i], exp_q[i]);
        if (b2b)
            for (int i = 1; i < stamp_q.size(); i++)
                chk({tag, "_b2b"}, stamp_q[i] - stamp_q[i-1], 1);
        got_q.delete();
        exp_q.delete();
        stamp_q.delete();
    endtask

    task automatic check_errs(input string tag);
        chk({tag, "_err_crc"}, n_crc, e_crc);
        chk({tag, "_err_len"}, n_len, e_len);
        chk({tag, "_err_to"},  n_to,  e_to);
        chk({tag, "_err_ovr"}, n_ovr, e_ovr);
    endtask

    task automatic good_frame_3();
        pl = '{8'h11, 8'h22, 8'h33};
        send_good(1);
        drain(0);
    endtask

    initial begin
        int nv0;
        int k;
        rst_n     = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'd0;
        pay_ready = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pay_data", pay_data, 0);
        chk("rst_pay_valid", pay_valid, 0);
        chk("rst_pay_last", pay_last, 0);
        chk("rst_errs", {err_crc, err_len, err_timeout, err_ovr}, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Good frame A5 03 11 22 33 97, first byte one cycle after CSUM
        tx_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
        send_q(1);
        @(negedge clk);
        chk("lat_valid", pay_valid, 1);
        chk("lat_data", pay_data, 8'h11);
        drain(0);
        exp_q = '{9'h011, 9'h022, 9'h133};
        check_stream("good", 1);
        check_errs("good");

        // Bad checksum, then a good frame
        nv0  = n_valid;
        tx_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00};
        send_q(1);
        drain(0);
        e_crc++;
        chk("crc_no_valid", n_valid - nv0, 0);
        check_stream("crc", 0);
        check_errs("crc");
        good_frame_3();
        check_stream("after_crc", 1);

        // Garbage then length errors (zero and MAX_LEN+1)
        tx_q = '{8'h00, 8'hFF, 8'hA5, 8'h00};
        send_q(1);
        tx_q = '{8'hA5, 8'h11};
        send_q(1);
        @(negedge clk);
        @(negedge clk);
        e_len += 2;
        chk("len_busy", busy, 0);
        check_errs("len");
        good_frame_3();
        check_stream("after_len", 1);

        // Backpressure with an overrun byte injected
        pay_ready = 1'b0;
        pl = '{8'h11, 8'h22, 8'h33};
        send_good(1);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            rx_valid = (i == 5);
            rx_data  = 8'h55;
            @(negedge clk);
            chk("bp_hold", {pay_valid, pay_last, pay_data}, {1'b1, 1'b0, 8'h11});
        end
        rx_valid = 1'b0;
        e_ovr++;
        drain(0);
        check_stream("bp", 0);
        check_errs("bp");

        // Inter-byte timeout
        tx_q = '{8'hA5, 8'h03, 8'h11};
        send_q(1);
`ifdef UART_FRAME_PARSER_TIMEOUT_EN
        k = 0;
        for (int i = 1; i <= 300 && k == 0; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (err_timeout) k = i;
        end
        chk("tmo_delay", k, 100);
        e_to++;
        @(negedge clk);
        chk("tmo_busy", busy, 0);
        check_errs("tmo");
`else
        k = 0;
        repeat (300) @(negedge clk);
        chk("notmo_busy", busy, 1);
        chk("notmo_err", n_to, 0);
        tx_q = '{8'h22, 8'h33, 8'h97};
        send_q(1);
        drain(0);
        exp_q = '{9'h011, 9'h022, 9'h133};
        check_stream("notmo_resume", 0);
`endif

        // Reset mid-frame
        tx_q = '{8'hA5, 8'h03, 8'h11};
        send_q(1);
        @(negedge clk);
        chk("mid_busy_pre", busy, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {pay_data, pay_valid, pay_last, err_crc, err_len, err_timeout, err_ovr, busy}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        nv0  = n_valid;
        tx_q = '{8'h22, 8'h33, 8'h97};
        send_q(1);
        repeat (5) @(negedge clk);
        chk("mid_no_valid", n_valid - nv0, 0);
        chk("mid_busy_post", busy, 0);
        check_stream("mid", 0);
        good_frame_3();
        check_stream("after_mid", 1);
        check_errs("mid");

        // Randomized frames with random gaps, garbage and backpressure
        for (int f = 0; f < 40; f++) begin
            int kind;
            int len;
            logic [7:0] g;
            repeat ($urandom_range(0, 2)) begin
                g = 8'($urandom_range(0, 255));
                if (g == 8'hA5) g = 8'h5A;
                send_byte(g, $urandom_range(0, 2));
            end
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 255);
                tx_q = '{8'hA5, 8'(len)};
                send_q($urandom_range(0, 2));
                e_len++;
            end else begin
                len = $urandom_range(1, MAX_LEN);
                pl.delete();
                for (int i = 0; i < len; i++) pl.push_back(8'($urandom_range(0, 255)));
                if (kind <= 2) begin
                    tx_q.push_back(8'hA5);
                    tx_q.push_back(8'(len));
                    foreach (pl[i]) tx_q.push_back(pl[i]);
                    tx_q.push_back(csum_of(len, pl) ^ 8'($urandom_range(1, 255)));
                    send_q($urandom_range(0, 2));
                    e_crc++;
                end else begin
                    send_good($urandom_range(0, 2));
                end
            end
            drain(1);
        end
        repeat (2) @(negedge clk);
        check_stream("rand", 0);
        check_errs("rand");
        chk("hold_stable", n_hold_bad, 0);
        chk("hold_exercised", n_hold_seen > 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_frame_parser.md
# uart_frame_parser

Byte-level frame decoder sitting directly downstream of the UART receiver: it consumes the receiver's 8-bit `data` / single-cycle `data_valid` stream, hunts for a start-of-frame byte, checks length and checksum, and buffers the payload. Only frames that pass the checksum are released, as a valid/ready byte stream with an end-of-frame marker, to the command layer. Malformed, timed-out and overrun frames are reported as one-cycle error pulses.

## Interface
- `CLK_FREQ`, 100000000, clock frequency in Hz; sets the inter-byte timeout.
- `MAX_LEN`, 16, maximum payload length in bytes (1..255); sets the buffer depth.
- `SOF`, 8'hA5, start-of-frame byte value.
- `TIMEOUT_CYC`, CLK_FREQ/1000, inter-byte timeout in clock cycles (1 ms).
- `clk`  in  1  system clock, all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  byte from the UART receiver; sampled only when `rx_valid`=1.
- `rx_valid`  in  1  single-cycle byte strobe from the UART receiver.
- `pay_data`  out  8  payload byte.
- `pay_valid`  out  1  `pay_data` is valid.
- `pay_last`  out  1  the current byte is the final payload byte of the frame.
- `pay_ready`  in  1  downstream accepts the byte.
- `err_crc`  out  1  one-cycle pulse: checksum mismatch.
- `err_len`  out  1  one-cycle pulse: LEN = 0 or LEN > MAX_LEN.
- `err_timeout`  out  1  one-cycle pulse: inter-byte timeout expired.
- `err_ovr`  out  1  one-cycle pulse: a byte arrived while output was draining.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Frame format: SOF, LEN, LEN payload bytes, CSUM. The frame is valid when (LEN + sum of payload + CSUM) mod 256 = 0, using an 8-bit wrapping sum.
- IDLE: bytes other than `SOF` are silently discarded. On `SOF`, go to LEN.
- LEN: on a byte equal to 0 or greater than MAX_LEN, pulse `err_len` and return to IDLE. Otherwise store the byte as LEN, initialise the sum to LEN, clear the write pointer, and go to PAYLOAD.
- PAYLOAD: write each byte into the buffer at the write pointer and add it to the sum. After the LEN-th byte, go to CSUM.
- CSUM: if sum + byte = 0 mod 256, go to OUT. Otherwise pulse `err_crc` and return to IDLE; nothing is emitted.
- OUT: present buffer[rd_ptr] on `pay_data` with `pay_valid`=1. `pay_last` is 1 when rd_ptr = LEN-1. On `pay_valid && pay_ready`, increment rd_ptr. After the last handshake, return to IDLE.
- In OUT, any `rx_valid` byte is discarded and pulses `err_ovr`. A SOF byte arriving during OUT is also lost.
- Timeout (LEN, PAYLOAD and CSUM states only): a cycle counter clears on each `rx_valid` and otherwise increments. When it reaches TIMEOUT_CYC, pulse `err_timeout` and go to IDLE.
- Reset, including mid-frame: state IDLE, pointers, sum and counter cleared. Buffered bytes are never emitted after reset.

## Timing
- Reset values: `pay_data`=0, `pay_valid`=0, `pay_last`=0, all `err_*`=0, `busy`=0.
- All outputs are registered. Error pulses rise exactly one cycle after the offending `rx_valid` cycle (or after the timeout cycle) and last one cycle.
- Latency: `pay_valid` rises one cycle after the `rx_valid` cycle carrying CSUM.
- Under continuous `pay_ready`=1, one byte is emitted per cycle.
- `pay_valid`, `pay_data` and `pay_last` hold stable while `pay_ready`=0.
- `pay_valid` drops the cycle after the last handshake. The next SOF is accepted from that cycle on.
- `rx_valid` is never closer than one UART character time, so at most one byte arrives per cycle. No input buffering beyond the frame buffer.

## Configuration
- `UART_FRAME_PARSER_TIMEOUT_EN` defined: the timeout counter and `err_timeout` are implemented as described.
- Not defined: no counter is built, `err_timeout` is tied to 0, and the parser waits indefinitely in LEN, PAYLOAD and CSUM.

## Test plan
- Good frame: send A5 03 11 22 33 97 -> emits 11, 22, 33 with `pay_last` only on 33; no error pulses.
- Bad checksum: send A5 03 11 22 33 00 -> single `err_crc` pulse; `pay_valid` never rises; a following good frame decodes correctly.
- Length errors: send A5 00, then A5 11 with MAX_LEN=16 -> `err_len` pulses once for each, then the parser is back in IDLE; leading garbage bytes 00 FF before A5 are ignored.
- Backpressure and overrun: good frame with `pay_ready` held low for 20 cycles and a byte 55 injected meanwhile -> `pay_data`=11 held stable, `err_ovr` pulses once, all 3 bytes then delivered in order.
- Timeout (macro defined, TIMEOUT_CYC=100): send A5 03 11 then silence -> `err_timeout` pulses 100 cycles after 11 arrives; with the macro undefined, no pulse and `busy` stays 1.
- Reset mid-frame: `rst_n` low after A5 03 11 -> all outputs 0 immediately; then send 22 33 97 -> nothing emitted; a full good frame afterwards decodes correctly.
